// File: rtl/mplier_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One radix-4 Booth digit: value is (neg ? -1 : +1) * (two ? 2 : 1) * A, or 0.
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t d;
    d.zero = (bits == 3'b000) || (bits == 3'b111);
    d.two  = (bits == 3'b011) || (bits == 3'b100);
    d.neg  = bits[2] && !d.zero;
    return d;
  endfunction

  function automatic int mplier_iters(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int mplier_cnt_w(input int width);
    return $clog2(mplier_iters(width) + 1);
  endfunction

endpackage

// File: rtl/mplier_booth_pp.sv
// Radix-4 Booth partial-product generator: digit * A, sign-extended and
// shifted to weight 4^idx within the accumulator width.
module mplier_booth_pp
  import mplier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = mplier_cnt_w(WIDTH)
) (
  input  logic [WIDTH+1:0]     a_ext,
  input  booth_digit_t         digit,
  input  logic [CW-1:0]        idx,
  output logic [2*WIDTH+3:0]   pp
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;

  logic [EW:0]   mag;
  logic [AW-1:0] mag_ext;
  logic [AW-1:0] val;

  always_comb begin
    mag     = digit.two ? {a_ext, 1'b0} : {a_ext[EW-1], a_ext};
    mag_ext = {{(AW-EW-1){mag[EW]}}, mag};
    if (digit.zero) begin
      val = '0;
    end else if (digit.neg) begin
      val = -mag_ext;
    end else begin
      val = mag_ext;
    end
    pp = val << {idx, 1'b0};
  end

endmodule

// File: rtl/mplier_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per op.
// Optional MPLIER_SEQ_EARLY_EXIT_EN: finish as soon as the remaining Booth digits are all zero.
module mplier_seq
  import mplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = mplier_iters(WIDTH);
  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = mplier_cnt_w(WIDTH);
  localparam int MW = EW + 1;

  state_t         state;
  state_t         state_next;
  logic [EW-1:0]  a_ext;
  logic [MW-1:0]  mreg;
  logic [MW-1:0]  mreg_shift;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  pp;
  logic [CW-1:0]  cnt;
  logic           last_iter;
  logic           early_exit;
  booth_digit_t   digit;

  // mreg holds {extended b, b[-1]}; its low three bits are always the current Booth window.
  assign digit      = booth_decode(mreg[2:0]);
  assign mreg_shift = {{2{mreg[MW-1]}}, mreg[MW-1:2]};
  assign last_iter  = (cnt == CW'(N - 1));

`ifdef MPLIER_SEQ_EARLY_EXIT_EN
  // Arithmetic shift replicates the top bit, so all-equal bits mean every later digit is zero.
  assign early_exit = (mreg_shift == '0) || (&mreg_shift);
`else
  assign early_exit = 1'b0;
`endif

  mplier_booth_pp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_pp (
    .a_ext (a_ext),
    .digit (digit),
    .idx   (cnt),
    .pp    (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = BUSY;
      BUSY: if (last_iter || early_exit) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext <= '0;
      mreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext <= {{2{in_signed & a[WIDTH-1]}}, a};
            mreg  <= {{2{in_signed & b[WIDTH-1]}}, b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc  <= acc + pp;
          mreg <= mreg_shift;
          cnt  <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc[2*WIDTH-1:0];

endmodule

// File: doc/mplier_seq.md
# mplier_seq

Sequential radix-4 Booth multiplier. It is the parametrised successor to the 8x8 combinational multiplier. It computes a full-precision WIDTH x WIDTH product over several cycles, and each operation can be signed or unsigned. Valid/ready handshakes on the input and output sides let it sit behind operand FIFOs in datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand width; even, 4..32; product is 2*WIDTH bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer takes product
- product  output  2*WIDTH  a*b, two's complement if in_signed, else unsigned

## Operation
- Decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a, b and in_signed.
  - Extend a and b to WIDTH+2 bits (sign-extend if in_signed, else zero-extend).
  - Clear the accumulator and the iteration counter; go to BUSY.
- BUSY:
  - One radix-4 Booth digit per cycle, taken from bits {b[2i+1], b[2i], b[2i-1]} with b[-1]=0.
  - Digit values: 0, ±A, ±2A; adds to the accumulator at weight 4^i.
  - N = WIDTH/2+1 iterations. After the Nth, go to DONE.
- DONE:
  - out_valid=1; product is the low 2*WIDTH bits of the accumulator, held stable.
  - On out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid in BUSY or DONE is ignored, and the operands are not sampled.
- in_signed, a and b are sampled only at the accept edge. Later changes have no effect.
- Accumulator width is 2*WIDTH+4 bits internally. The truncated result equals the exact product in both modes, with no overflow possible.
- Boundary cases:
  - Signed: -2^(WIDTH-1) x -2^(WIDTH-1) gives +2^(2*WIDTH-2), which is exact.
  - Unsigned: (2^WIDTH-1)^2 is exact.
  - Zero operands still take the full iteration count unless early exit is compiled in.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, product=0; the accumulator and counter are cleared.
- Accept edge is T0. out_valid rises after edge T0+N, i.e. N cycles after the accept edge. For WIDTH=8 that is 5 cycles.
- Once out_valid rises, it and product are held until the edge at which out_ready=1. At that edge, out_valid falls and in_ready rises.
- Minimum issue interval is N+2 cycles.
- out_ready high before out_valid has no effect.
- Reset asserted mid-operation: state returns to IDLE immediately (asynchronously) and the in-flight result is discarded. No out_valid is produced for that operation.
- Registered outputs only. There are no combinational paths from inputs to outputs.

## Configuration
- MPLIER_SEQ_EARLY_EXIT_EN:
  - Defined: in BUSY, if the remaining unconsumed bits of extended b plus the current overlap bit are all equal (all 0s or all 1s), go to DONE at the next edge. Latency becomes 1..N cycles, data dependent; e.g. b=0 gives latency 1.
  - Undefined: latency is fixed at N.
- Results are identical with and without the macro.

## Structure
- The package mplier_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - the Booth digit encoding type;
  - a booth_decode function (3 bits -> {neg, two, zero});
  - the constant function for N from WIDTH.
- Sub-module mplier_booth_pp (parameter WIDTH) takes the extended A and a digit, and returns the 2*WIDTH+4-bit shifted partial product. It is instantiated once.
- The top level holds the FSM, counter, shifting multiplier register and accumulator.

## Test plan
- Signed: a=8'h80, b=8'h80 (-128 x -128) -> product 16'h4000 after 5 cycles.
- Unsigned: a=8'hFF, b=8'hFF -> 16'hFE01. The same operands with in_signed=1 -> 16'h0001.
- Backpressure: out_ready held low for 10 cycles -> product stable and in_ready=0 throughout. in_valid pulses in that window are not accepted.
- Reset mid-BUSY: rst_n low at cycle 2 after accept -> out_valid=0, in_ready=1 immediately. The next op a=-1, b=1 signed -> 16'hFFFF.
- Sweep (WIDTH=8):
  - a and b from -128 to 127 in steps of 10, signed and unsigned, back-to-back.
  - Check every product against the reference multiply.
  - Check latency is 5 without the macro, and 1..5 with MPLIER_SEQ_EARLY_EXIT_EN.
- WIDTH=16 instance: a=16'h8000, b=16'h7FFF signed -> 32'hC0008000, latency 9.
